mem_stage: RTL and testbench

- Memory stage of the in-order pipeline, sitting directly downstream of the Execute/Memory pipeline register and feeding the Memory/Writeback register and the ROB.
- Performs loads and stores against a valid/ready data-memory port and formats load data per funct3.
- Flags misaligned or illegal accesses as exceptions.
- Raises stall back to the E/M register while a memory access is outstanding.

---
 rtl/mem_stage.sv | 122 ++++++++++++
 tb/tb_mem_stage.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage issuing loads/stores over a valid/ready port and formatting load data.
module mem_stage #(
  parameter int WORD_SIZE = 32,
  parameter int ROB_ID_W  = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid,
  input  logic [1:0]           instruction_type,
  input  logic [WORD_SIZE-1:0] pc,
  input  logic [2:0]           funct3,
  input  logic [WORD_SIZE-1:0] aluResult,
  input  logic [WORD_SIZE-1:0] s2,
  input  logic [ROB_ID_W-1:0]  rob_id,
  output logic                 stall_out,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [WORD_SIZE-1:0] mem_req_addr,
  output logic                 mem_req_we,
  output logic [WORD_SIZE-1:0] mem_req_wdata,
  output logic [3:0]           mem_req_wstrb,
  input  logic                 mem_resp_valid,
  input  logic [WORD_SIZE-1:0] mem_resp_rdata,
  output logic                 wb_valid,
  output logic [WORD_SIZE-1:0] wb_pc,
  output logic [WORD_SIZE-1:0] wb_result,
  output logic [ROB_ID_W-1:0]  wb_rob_id,
  output logic                 wb_exception
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t state, state_nx;
  logic is_ld, is_st, is_mem, f_legal, aligned, legal, go;
  logic done_idle, done_req, done_resp, done;
  logic [WORD_SIZE-1:0] st_wdata, ld_data, sh;
  logic [3:0] st_wstrb;
  logic [15:0] half;
  logic [WORD_SIZE-1:0] r_addr, r_wdata, r_pc;
  logic [3:0] r_wstrb;
  logic [2:0] r_funct3;
  logic [ROB_ID_W-1:0] r_rob;
  logic r_we;
  assign is_ld   = instruction_type == 2'b01;
  assign is_st   = instruction_type == 2'b10;
  assign is_mem  = is_ld | is_st;
  assign f_legal = is_ld ? funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}
                         : funct3 inside {3'b000, 3'b001, 3'b010};
  assign aligned = funct3[1:0] == 2'b01 ? !aluResult[0] :
                   funct3[1:0] == 2'b10 ? aluResult[1:0] == 2'b00 : 1'b1;
  assign legal   = f_legal & aligned;
  assign go      = state == IDLE & valid & is_mem & legal;
  assign st_wdata = funct3[1:0] == 2'b00 ? {4{s2[7:0]}} :
                    funct3[1:0] == 2'b01 ? {2{s2[15:0]}} : s2;
  assign st_wstrb = !is_st ? 4'b0000 :
                    funct3[1:0] == 2'b00 ? 4'b0001 << aluResult[1:0] :
                    funct3[1:0] == 2'b01 ? (aluResult[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  // REQ replays the latched request so the port stays stable while the master waits
  assign mem_req_valid = go | state == REQ;
  assign mem_req_addr  = state == REQ ? {r_addr[WORD_SIZE-1:2], 2'b00} : {aluResult[WORD_SIZE-1:2], 2'b00};
  assign mem_req_we    = state == REQ ? r_we : is_st;
  assign mem_req_wdata = state == REQ ? r_wdata : st_wdata;
  assign mem_req_wstrb = state == REQ ? r_wstrb : st_wstrb;
  assign done_idle = state == IDLE & valid & (!is_mem | !legal | (is_st & mem_req_ready));
  assign done_req  = state == REQ & r_we & mem_req_ready;
  assign done_resp = state == RESP & mem_resp_valid;
  assign done      = done_idle | done_req | done_resp;
  assign stall_out = valid & is_mem & legal & !done;
  assign sh   = mem_resp_rdata >> {r_addr[1:0], 3'b000};
  assign half = r_addr[1] ? mem_resp_rdata[31:16] : mem_resp_rdata[15:0];
  assign ld_data = r_funct3 == 3'b000 ? {{(WORD_SIZE-8){sh[7]}}, sh[7:0]} :
                   r_funct3 == 3'b001 ? {{(WORD_SIZE-16){half[15]}}, half} :
                   r_funct3 == 3'b100 ? {{(WORD_SIZE-8){1'b0}}, sh[7:0]} :
                   r_funct3 == 3'b101 ? {{(WORD_SIZE-16){1'b0}}, half} : mem_resp_rdata;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = !go ? IDLE : !mem_req_ready ? REQ : is_st ? IDLE : RESP;
      REQ:  state_nx = !mem_req_ready ? REQ : r_we ? IDLE : RESP;
      RESP: state_nx = mem_resp_valid ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_we     <= 1'b0;
      r_funct3 <= '0;
      r_pc     <= '0;
      r_rob    <= '0;
    end else begin
      state <= state_nx;
      if (go) begin
        r_addr   <= aluResult;
        r_wdata  <= st_wdata;
        r_wstrb  <= st_wstrb;
        r_we     <= is_st;
        r_funct3 <= funct3;
        r_pc     <= pc;
        r_rob    <= rob_id;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid     <= 1'b0;
      wb_pc        <= '0;
      wb_result    <= '0;
      wb_rob_id    <= '0;
      wb_exception <= 1'b0;
    end else begin
      wb_valid <= done;
      if (done) begin
        wb_pc        <= done_idle ? pc : r_pc;
        wb_rob_id    <= done_idle ? rob_id : r_rob;
        wb_result    <= done_resp ? ld_data : done_idle ? aluResult : r_addr;
        wb_exception <= done_idle & is_mem & !legal;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed stimulus with a queued scoreboard checked by an independent writeback monitor.
module tb_mem_stage;
  logic clk = 0, rst_n = 0, valid = 0;
  logic [1:0] instruction_type = 0;
  logic [31:0] pc = 0, aluResult = 0, s2 = 0;
  logic [2:0] funct3 = 0;
  logic [6:0] rob_id = 0;
  logic stall_out, mem_req_valid, mem_req_we, mem_req_ready = 0, mem_resp_valid = 0;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_rdata = 0;
  logic [3:0] mem_req_wstrb;
  logic wb_valid, wb_exception;
  logic [31:0] wb_pc, wb_result;
  logic [6:0] wb_rob_id;
  typedef struct {logic [31:0] pc; logic [31:0] res; logic [6:0] rob; logic exc; logic chk_res;} exp_t;
  exp_t q[$];
  int total = 0, passed = 0;
  mem_stage dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .instruction_type(instruction_type), .pc(pc),
    .funct3(funct3), .aluResult(aluResult), .s2(s2), .rob_id(rob_id), .stall_out(stall_out),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata), .wb_valid(wb_valid),
    .wb_pc(wb_pc), .wb_result(wb_result), .wb_rob_id(wb_rob_id), .wb_exception(wb_exception)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(logic [1:0] t, logic [2:0] f, logic [31:0] a, logic [31:0] d, logic [6:0] r, logic [31:0] p);
    valid = 1; instruction_type = t; funct3 = f; aluResult = a; s2 = d; rob_id = r; pc = p;
  endtask
  task automatic push(logic [31:0] p, logic [31:0] res, logic [6:0] r, logic e, logic c);
    exp_t x;
    x.pc = p; x.res = res; x.rob = r; x.exc = e; x.chk_res = c;
    q.push_back(x);
  endtask
  always @(negedge clk) begin
    if (rst_n && wb_valid) begin
      if (q.size() == 0) chk("unexpected_wb_valid", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("wb_pc", wb_pc, e.pc);
        chk("wb_rob_id", {25'd0, wb_rob_id}, {25'd0, e.rob});
        chk("wb_exception", {31'd0, wb_exception}, {31'd0, e.exc});
        if (e.chk_res) chk("wb_result", wb_result, e.res);
      end
    end
  end
  task automatic store(logic [2:0] f, logic [31:0] a, logic [31:0] d, logic [6:0] r, logic [31:0] p,
                       int waits, logic [3:0] strb, logic [31:0] wd);
    drive(2'b10, f, a, d, r, p);
    mem_req_ready = 0;
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      chk("st_wait_stall", {31'd0, stall_out}, 1);
      chk("st_wait_addr", mem_req_addr, {a[31:2], 2'b00});
      chk("st_wait_wstrb", {28'd0, mem_req_wstrb}, {28'd0, strb});
      chk("st_wait_wdata", mem_req_wdata, wd);
      tick;
    end
    mem_req_ready = 1;
    @(negedge clk);
    chk("st_req_valid", {31'd0, mem_req_valid}, 1);
    chk("st_we", {31'd0, mem_req_we}, 1);
    chk("st_wstrb", {28'd0, mem_req_wstrb}, {28'd0, strb});
    chk("st_wdata", mem_req_wdata, wd);
    chk("st_done_stall", {31'd0, stall_out}, 0);
    push(p, a, r, 0, 0);
    tick;
    mem_req_ready = 0; valid = 0;
    tick;
  endtask
  task automatic load(logic [2:0] f, logic [31:0] a, logic [31:0] rd, int lat, logic [6:0] r,
                      logic [31:0] p, logic [31:0] exp);
    drive(2'b01, f, a, 0, r, p);
    mem_req_ready = 1;
    @(negedge clk);
    chk("ld_req_valid", {31'd0, mem_req_valid}, 1);
    chk("ld_we", {31'd0, mem_req_we}, 0);
    chk("ld_wstrb", {28'd0, mem_req_wstrb}, 0);
    chk("ld_addr", mem_req_addr, {a[31:2], 2'b00});
    chk("ld_issue_stall", {31'd0, stall_out}, 1);
    tick;
    mem_req_ready = 0;
    for (int i = 0; i < lat - 1; i++) begin
      @(negedge clk);
      chk("ld_wait_stall", {31'd0, stall_out}, 1);
      chk("ld_wait_no_req", {31'd0, mem_req_valid}, 0);
      tick;
    end
    mem_resp_valid = 1; mem_resp_rdata = rd;
    @(negedge clk);
    chk("ld_done_stall", {31'd0, stall_out}, 0);
    push(p, exp, r, 0, 1);
    tick;
    mem_resp_valid = 0; valid = 0;
    tick;
  endtask
  task automatic fault(logic [2:0] f, logic [31:0] a, logic [6:0] r, logic [31:0] p);
    drive(2'b01, f, a, 0, r, p);
    mem_req_ready = 1;
    @(negedge clk);
    chk("exc_no_req", {31'd0, mem_req_valid}, 0);
    chk("exc_stall", {31'd0, stall_out}, 0);
    push(p, a, r, 1, 1);
    tick;
    mem_req_ready = 0; valid = 0;
    tick;
  endtask
  task automatic alu(logic [31:0] a, logic [6:0] r, logic [31:0] p);
    drive(2'b00, 0, a, 0, r, p);
    @(negedge clk);
    chk("alu_no_req", {31'd0, mem_req_valid}, 0);
    chk("alu_stall", {31'd0, stall_out}, 0);
    push(p, a, r, 0, 1);
    tick;
    valid = 0;
    tick;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    tick; tick;
    @(negedge clk);
    chk("rst_wb_valid", {31'd0, wb_valid}, 0);
    chk("rst_wb_result", wb_result, 0);
    chk("rst_wb_pc", wb_pc, 0);
    chk("rst_req_valid", {31'd0, mem_req_valid}, 0);
    tick;
    rst_n = 1;
    tick;
    alu(32'h1234_5678, 7'd5, 32'h100);
    store(3'b000, 32'h1003, 32'h0000_00AB, 7'd6, 32'h104, 2, 4'b1000, 32'hABAB_ABAB);
    store(3'b001, 32'h1002, 32'h1234_CAFE, 7'd7, 32'h108, 0, 4'b1100, 32'hCAFE_CAFE);
    store(3'b010, 32'h1008, 32'hDEAD_BEEF, 7'd8, 32'h10C, 1, 4'b1111, 32'hDEAD_BEEF);
    load(3'b000, 32'h2002, 32'h0080_0000, 3, 7'd11, 32'h110, 32'hFFFF_FF80);
    load(3'b100, 32'h2002, 32'h0080_0000, 3, 7'd12, 32'h114, 32'h0000_0080);
    load(3'b001, 32'h2002, 32'h8001_1234, 1, 7'd13, 32'h118, 32'hFFFF_8001);
    load(3'b101, 32'h2002, 32'h8001_1234, 2, 7'd14, 32'h11C, 32'h0000_8001);
    load(3'b010, 32'h2004, 32'hCAFE_F00D, 1, 7'd15, 32'h120, 32'hCAFE_F00D);
    load(3'b000, 32'h2001, 32'h0000_7F00, 1, 7'd16, 32'h124, 32'h0000_007F);
    fault(3'b010, 32'h3001, 7'd20, 32'h130);
    fault(3'b011, 32'h3000, 7'd21, 32'h134);
    fault(3'b001, 32'h3003, 7'd22, 32'h138);
    drive(2'b01, 3'b010, 32'h2004, 0, 7'd9, 32'h140);
    mem_req_ready = 1;
    tick;
    mem_req_ready = 0; valid = 0; rst_n = 0;
    @(negedge clk);
    chk("rst2_wb_valid", {31'd0, wb_valid}, 0);
    chk("rst2_wb_result", wb_result, 0);
    chk("rst2_wb_pc", wb_pc, 0);
    chk("rst2_wb_rob_id", {25'd0, wb_rob_id}, 0);
    chk("rst2_wb_exception", {31'd0, wb_exception}, 0);
    tick;
    rst_n = 1;
    mem_resp_valid = 1; mem_resp_rdata = 32'h5555_5555;
    tick;
    mem_resp_valid = 0;
    @(negedge clk);
    chk("post_rst_wb_valid", {31'd0, wb_valid}, 0);
    chk("post_rst_wb_result", wb_result, 0);
    chk("post_rst_stall", {31'd0, stall_out}, 0);
    tick;
    alu(32'h0000_0077, 7'd3, 32'h200);
    tick; tick;
    chk("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
